// File: rtl/pio_cmd_pkg.sv
// Shared types and field positions for the HPS command/response PIO responder.
// The command byte is {toggle, opcode[2:0], data[3:0]}; the response is {toggle, err, payload[5:0]}.
package pio_cmd_pkg;

   typedef enum logic [2:0] {
      OP_NOP      = 3'd0,
      OP_SET_ADDR = 3'd1,
      OP_WR_LO    = 3'd2,
      OP_WR_HI    = 3'd3,
      OP_RD_LO    = 3'd4,
      OP_RD_HI    = 3'd5,
      OP_RD_STAT  = 3'd6,
      OP_PULSE    = 3'd7
   } opcode_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECODE = 2'd1,
      ST_PULSE  = 2'd2
   } state_t;

   localparam int TOG_BIT   = 7;
   localparam int ERR_BIT   = 6;
   localparam int OP_MSB    = 6;
   localparam int OP_LSB    = 4;
   localparam int PAYLOAD_W = 6;
   localparam int REG_COUNT = 4;

   function automatic logic [7:0] make_rsp(input logic tog, input logic err,
                                           input logic [PAYLOAD_W-1:0] payload);
      return {tog, err, payload};
   endfunction

endpackage

// File: rtl/pio_pulse_gen.sv
// Single-shot strobe generator: start loads a 16-bit down-counter and lights one channel
// until the count has run from PULSE_LEN-1 down to 0.
module pio_pulse_gen #(
   parameter int unsigned PULSE_LEN = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] ch,
   output logic [3:0] pulse_o,
   output logic       done
);

   localparam logic [15:0] LOAD = 16'(PULSE_LEN - 1);

   logic [15:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count   <= '0;
         pulse_o <= '0;
      end else if (start) begin
         count   <= LOAD;
         pulse_o <= 4'b0001 << ch;
      end else if (pulse_o != 4'b0000) begin
         if (count == 16'd0) pulse_o <= '0;
         else                count   <= count - 16'd1;
      end
   end

   // Final strobe cycle: the owner acks on the same edge that clears the pulse.
   assign done = (pulse_o != 4'b0000) && (count == 16'd0);

endmodule

// File: rtl/pio_cmd_responder.sv
// Fabric-side responder for the HPS pio_0/pio_1 command/response pair using a toggle handshake.
// Executes one latched command per request and acks by copying the request toggle into rsp[7].
module pio_cmd_responder
   import pio_cmd_pkg::*;
#(
   parameter logic [5:0]  VERSION   = 6'h01,
   parameter int unsigned PULSE_LEN = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  hps_cmd_i,
   output logic [7:0]  hps_rsp_o,
   input  logic [5:0]  stat_i,
   output logic [31:0] reg_o,
   output logic [3:0]  pulse_o,
   output logic        busy_o
);

   state_t         state;
   logic [7:0]     cmd_q;
   logic [7:0]     cmd_r;
   logic [1:0]     addr;
   logic [3:0]     wdata_lo;
   logic [7:0]     regs [REG_COUNT];

   opcode_t        op;
   logic [3:0]     d;
   logic           pending;
   logic           pulse_start;
   logic           pulse_done;
   logic           dec_err;
   logic [PAYLOAD_W-1:0] dec_payload;

   assign op          = opcode_t'(cmd_r[OP_MSB:OP_LSB]);
   assign d           = cmd_r[3:0];
   assign pending     = cmd_q[TOG_BIT] ^ hps_rsp_o[TOG_BIT];
   assign pulse_start = (state == ST_DECODE) && (op == OP_PULSE) && (d[3:2] == 2'b00);

   always_comb begin
      dec_err     = 1'b0;
      dec_payload = '0;
      case (op)
         OP_NOP:      dec_payload = VERSION;
         OP_SET_ADDR: dec_payload = {d[1:0], 4'h0};
         OP_WR_LO:    dec_payload = {addr, d};
         OP_WR_HI:    dec_payload = {addr, d};
         OP_RD_LO:    dec_payload = {2'b00, regs[addr][3:0]};
         OP_RD_HI:    dec_payload = {2'b00, regs[addr][7:4]};
         OP_RD_STAT:  dec_payload = stat_i;
         OP_PULSE: begin
            dec_err     = (d[3:2] != 2'b00);
            dec_payload = {2'b00, d};
         end
      endcase
   end

   always_comb begin
      reg_o = '0;
      for (int i = 0; i < REG_COUNT; i++) reg_o[8*i +: 8] = regs[i];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         cmd_q     <= '0;
         cmd_r     <= '0;
         hps_rsp_o <= '0;
         addr      <= '0;
         wdata_lo  <= '0;
         busy_o    <= 1'b0;
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      end else begin
         cmd_q <= hps_cmd_i;
         case (state)
            ST_IDLE: begin
               if (pending) begin
                  cmd_r  <= cmd_q;
                  state  <= ST_DECODE;
                  busy_o <= 1'b1;
               end
            end
            ST_DECODE: begin
               case (op)
                  OP_SET_ADDR: addr     <= d[1:0];
                  OP_WR_LO:    wdata_lo <= d;
                  OP_WR_HI:    regs[addr] <= {d, wdata_lo};
                  default: ;
               endcase
               // A valid pulse defers the ack until the strobe finishes.
               if (pulse_start) begin
                  state <= ST_PULSE;
               end else begin
                  hps_rsp_o <= make_rsp(cmd_r[TOG_BIT], dec_err, dec_payload);
                  state     <= ST_IDLE;
                  busy_o    <= 1'b0;
               end
            end
            ST_PULSE: begin
               if (pulse_done) begin
                  hps_rsp_o <= make_rsp(cmd_r[TOG_BIT], 1'b0, {2'b00, d});
                  state     <= ST_IDLE;
                  busy_o    <= 1'b0;
               end
            end
            default: begin
               state  <= ST_IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

   pio_pulse_gen #(
      .PULSE_LEN (PULSE_LEN)
   ) u_pulse (
      .clk     (clk),
      .reset   (reset),
      .start   (pulse_start),
      .ch      (d[1:0]),
      .pulse_o (pulse_o),
      .done    (pulse_done)
   );

endmodule

// File: tb/tb_pio_cmd_responder.sv
// Directed bench for pio_cmd_responder: handshake latency, register file, status, strobes,
// reset during a pulse and toggle behaviour while busy.
module tb_pio_cmd_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  hps_cmd_i;
   logic [7:0]  hps_rsp_o;
   logic [5:0]  stat_i;
   logic [31:0] reg_o;
   logic [3:0]  pulse_o;
   logic        busy_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pio_cmd_responder #(
      .VERSION   (6'h01),
      .PULSE_LEN (16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .hps_cmd_i (hps_cmd_i),
      .hps_rsp_o (hps_rsp_o),
      .stat_i    (stat_i),
      .reg_o     (reg_o),
      .pulse_o   (pulse_o),
      .busy_o    (busy_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive a command, then count edges until the ack toggle matches; bounded at 200 edges.
   task automatic do_cmd(input logic [7:0] cmd, output int lat, output logic [3:0] pseen);
      @(negedge clk);
      hps_cmd_i = cmd;
      lat = 0;
      pseen = 4'b0000;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         lat++;
         pseen |= pulse_o;
         if (hps_rsp_o[7] == cmd[7]) break;
      end
   endtask

   int         lat;
   int         hi_cnt;
   logic [3:0] pseen;
   logic       busy_seen;

   initial begin
      reset     = 1'b1;
      hps_cmd_i = 8'h00;
      stat_i    = 6'h00;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rsp",   hps_rsp_o, 8'h00);
      check("reset_reg",   reg_o,     32'h0);
      check("reset_pulse", pulse_o,   4'h0);
      check("reset_busy",  busy_o,    1'b0);
      @(negedge clk);
      reset = 1'b0;

      // NOP, cycle by cycle
      @(negedge clk);
      hps_cmd_i = 8'h80;
      @(posedge clk); #1;
      check("nop_e1_busy", busy_o, 1'b0);
      @(posedge clk); #1;
      check("nop_e2_busy", busy_o, 1'b1);
      check("nop_e2_rsp",  hps_rsp_o, 8'h00);
      @(posedge clk); #1;
      check("nop_e3_rsp",  hps_rsp_o, 8'h81);
      check("nop_e3_busy", busy_o, 1'b0);

      // Register write sequence to reg[2]
      do_cmd(8'h12, lat, pseen);
      check("set_addr_rsp", hps_rsp_o, 8'h20);
      check("set_addr_lat", lat, 3);
      do_cmd(8'hA5, lat, pseen);
      check("wr_lo_rsp", hps_rsp_o, 8'hA5);
      do_cmd(8'h3A, lat, pseen);
      check("wr_hi_rsp", hps_rsp_o, 8'h2A);
      check("wr_hi_reg", reg_o, 32'h00A5_0000);
      do_cmd(8'hC0, lat, pseen);
      check("rd_lo_rsp", hps_rsp_o, 8'h85);
      do_cmd(8'h50, lat, pseen);
      check("rd_hi_rsp", hps_rsp_o, 8'h0A);

      stat_i = 6'h2B;
      do_cmd(8'hE0, lat, pseen);
      check("rd_stat_rsp", hps_rsp_o, 8'hAB);

      // Valid pulse on channel 1
      @(negedge clk);
      hps_cmd_i = 8'h71;
      lat = 0;
      hi_cnt = 0;
      pseen = 4'b0000;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (pulse_o == 4'b0010) hi_cnt++;
         else pseen |= pulse_o;
         if (hps_rsp_o[7] == 1'b0) break;
      end
      check("pulse_rsp",    hps_rsp_o, 8'h01);
      check("pulse_width",  hi_cnt, 16);
      check("pulse_lat",    lat, 19);
      check("pulse_drop",   pulse_o, 4'h0);
      check("pulse_other",  pseen, 4'h0);

      // Invalid pulse channel
      do_cmd(8'hF4, lat, pseen);
      check("bad_pulse_rsp",  hps_rsp_o, 8'hC4);
      check("bad_pulse_lat",  lat, 3);
      check("bad_pulse_seen", pseen, 4'h0);

      // Reset while a pulse is counting (count 8 after 10 edges)
      @(negedge clk);
      hps_cmd_i = 8'h72;
      repeat (10) @(posedge clk);
      #1;
      check("mid_pulse_on", pulse_o, 4'b0100);
      @(negedge clk);
      reset = 1'b1;
      hps_cmd_i = 8'h00;
      @(posedge clk); #1;
      check("mid_reset_pulse", pulse_o, 4'h0);
      check("mid_reset_rsp",   hps_rsp_o, 8'h00);
      check("mid_reset_reg",   reg_o, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      busy_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         busy_seen |= busy_o;
      end
      check("post_reset_busy", busy_seen, 1'b0);
      check("post_reset_rsp",  hps_rsp_o, 8'h00);

      // Toggle flipped twice during a pulse: single ack, no second request
      @(negedge clk);
      hps_cmd_i = 8'hF3;
      repeat (5) @(posedge clk);
      @(negedge clk);
      hps_cmd_i = 8'h73;
      repeat (3) @(posedge clk);
      @(negedge clk);
      hps_cmd_i = 8'hF3;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (hps_rsp_o[7] == 1'b1) break;
      end
      check("dbl_flip_rsp", hps_rsp_o, 8'h83);
      busy_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         busy_seen |= busy_o;
      end
      check("dbl_flip_idle", busy_seen, 1'b0);
      check("dbl_flip_hold", hps_rsp_o, 8'h83);

      // Toggle flipped once during a pulse: queued NOP runs right after the ack
      @(negedge clk);
      hps_cmd_i = 8'h70;
      repeat (5) @(posedge clk);
      @(negedge clk);
      hps_cmd_i = 8'h80;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (hps_rsp_o[7] == 1'b0) break;
      end
      check("single_flip_ack1", hps_rsp_o, 8'h00);
      lat = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         lat++;
         if (hps_rsp_o[7] == 1'b1) break;
      end
      check("single_flip_ack2", hps_rsp_o, 8'h81);
      check("single_flip_lat",  lat, 2);

      // Data field change without a toggle is ignored
      @(negedge clk);
      hps_cmd_i = 8'h8F;
      busy_seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         busy_seen |= busy_o;
      end
      check("no_toggle_busy", busy_seen, 1'b0);
      check("no_toggle_rsp",  hps_rsp_o, 8'h81);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
